// File: rtl/fetch_unit.sv
// PC/fetch stage: fetches one word per cycle into a 2-entry {pc, instr} buffer, 1-cycle fetch latency.
// Backpressure via out_valid/out_ready; full buffer holds the PC; redirect flushes; bad PC traps sticky.
module fetch_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 512,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] instr_addr,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [ADDR_WIDTH-1:0] out_pc_plus4,
    output logic                  fault,
    output logic [ADDR_WIDTH-1:0] fault_addr
);
    typedef enum logic {RUN, FAULT} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    localparam logic [ADDR_WIDTH-2:0] MEM_WORDS = (ADDR_WIDTH-1)'(MEM_SIZE);

    state_t          state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [1:0]      count;
    entry_t          buf0;
    entry_t          buf1;
    entry_t          new_entry;
    logic            pc_legal;
    logic            pop;
    logic            push;
    logic            flush;

    // Legality is checked on the PC itself, so a wrapped or past-the-end PC is never fetched.
    assign pc_legal  = (pc[1:0] == 2'b00) && ({1'b0, pc[ADDR_WIDTH-1:2]} < MEM_WORDS);
    assign pop       = out_valid && out_ready;
    assign flush     = (state == RUN) && redirect_valid;
    assign push      = (state == RUN) && pc_legal && !redirect_valid && ((count != 2'd2) || pop);
    assign new_entry = '{pc: pc, instr: instr};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            pc         <= RESET_PC;
            count      <= 2'd0;
            buf0       <= '0;
            buf1       <= '0;
            fault      <= 1'b0;
            fault_addr <= '0;
        end else begin
            if ((state == RUN) && !pc_legal) begin
                state      <= FAULT;
                fault      <= 1'b1;
                fault_addr <= pc;
            end
            if (flush) begin
                count <= 2'd0;
                pc    <= redirect_target;
            end else begin
                if (push) begin
                    pc <= pc + ADDR_WIDTH'(4);
                end
                case ({push, pop})
                    2'b10: begin
                        if (count == 2'd0) begin
                            buf0 <= new_entry;
                        end else begin
                            buf1 <= new_entry;
                        end
                        count <= count + 2'd1;
                    end
                    2'b01: begin
                        buf0  <= buf1;
                        count <= count - 2'd1;
                    end
                    2'b11: begin
                        // Simultaneous push/pop keeps the count; the new entry lands behind whatever remains.
                        if (count == 2'd1) begin
                            buf0 <= new_entry;
                        end else begin
                            buf0 <= buf1;
                            buf1 <= new_entry;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign instr_addr   = pc;
    assign out_valid    = (count != 2'd0);
    assign out_instr    = buf0.instr;
    assign out_pc       = buf0.pc;
    assign out_pc_plus4 = buf0.pc + ADDR_WIDTH'(4);

endmodule
